// File: rtl/riscv_fetch_prefetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect
// and the valid/ready hand-off to decode.
interface riscv_fetch_prefetch_if #(
  parameter int DW = 32
);
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [DW-1:0] pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/riscv_fetch_prefetch.sv
// In-order instruction prefetcher with a small PC/word FIFO and redirect flush.
// Define FETCH_BYPASS_EN to let a response reach decode in the same cycle when the FIFO is empty.
module riscv_fetch_prefetch #(
  parameter int            DW         = 32,
  parameter int            ADDENT     = 4,
  parameter int            FIFO_DEPTH = 4,
  parameter logic [DW-1:0] RESET_PC   = '0
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  riscv_fetch_prefetch_if.master bus
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] NOP     = DW'(32'h0000_0013);

  typedef enum logic {FETCH, FLUSH} state_e;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  state_e        state, state_next;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, outs, outs_next, discard, discard_next;
  logic [DW-1:0] fetch_pc, resp_pc, last_pc;
  logic          started;
  logic          fifo_empty, grant, drop, accept, push, pop;
  logic          bypass_hit, bypass_take;

  // Outstanding + buffered never exceeds the FIFO, so a response always has a slot.
  assign bus.imem_req  = started && !bus.redirect &&
                         (({1'b0, count} + {1'b0, outs}) < DEPTH_C);
  assign bus.imem_addr = fetch_pc;

  assign fifo_empty = (count == '0);
  assign grant      = bus.imem_req && bus.imem_gnt;
  assign drop       = bus.imem_rvalid && (state == FLUSH);
  assign accept     = bus.imem_rvalid && (state == FETCH);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = fifo_empty && accept && !bus.redirect;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit && bus.instr_ready;
  assign push        = accept && !bypass_take && !bus.redirect;
  assign pop         = bus.instr_valid && bus.instr_ready && !fifo_empty;

  assign outs_next    = outs + CW'(grant) - CW'(bus.imem_rvalid);
  assign discard_next = bus.redirect ? outs_next : (discard - CW'(drop));

  // NOTE: every output gets a default first, so no path through this block infers a latch.
  always_comb begin
    bus.instr_valid = !fifo_empty || bypass_hit;
    bus.instr       = NOP;
    bus.pc          = last_pc;
    if (!fifo_empty) begin
      bus.instr = mem[rd_ptr].instr;
      bus.pc    = mem[rd_ptr].pc;
    end else if (bypass_hit) begin
      bus.instr = bus.imem_rdata;
      bus.pc    = resp_pc;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.redirect) begin
      state_next = (outs_next != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH && discard_next == '0) begin
      state_next = FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= FETCH;
    else         state <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started  <= 1'b0;
      count    <= '0;
      outs     <= '0;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      last_pc  <= RESET_PC;
    end else begin
      started <= 1'b1;
      last_pc <= bus.pc;
      outs    <= outs_next;
      discard <= discard_next;
      if (bus.redirect) begin
        // In-flight words are now stale; they drain through the discard counter.
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= bus.redirect_pc;
        resp_pc  <= bus.redirect_pc;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (grant)  fetch_pc <= fetch_pc + DW'(ADDENT);
        if (accept) resp_pc  <= resp_pc + DW'(ADDENT);
        if (push)   wr_ptr   <= wr_ptr + 1'b1;
        if (pop)    rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{pc: resp_pc, instr: bus.imem_rdata};
  end

endmodule
